// File: rtl/ttc_cfg_sched9.sv
// APB master that programs the triple timer counter and services its interrupts.
// One APB transfer is outstanding at a time; configuration and status reads share the port.
module ttc_cfg_sched9 #(
  parameter logic [7:0]  CLK_CTRL_BASE = 8'h00,
  parameter logic [7:0]  CNT_CTRL_BASE = 8'h0C,
  parameter logic [7:0]  INTERVAL_BASE = 8'h24,
  parameter logic [7:0]  IRQ_STAT_BASE = 8'h54,
  parameter logic [7:0]  IRQ_EN_BASE   = 8'h60,
  parameter logic [31:0] CNT_CTRL_RUN  = 32'h0000_0002
) (
  input  logic        pclk9,
  input  logic        n_p_reset9,
  input  logic        cfg_start9,
  input  logic [2:0]  cfg_tmr_en9,
  input  logic [6:0]  cfg_clk_ctrl9,
  input  logic [47:0] cfg_interval9,
  input  logic [5:0]  cfg_irq_en9,
  output logic        cfg_busy9,
  output logic        cfg_done9,
  output logic        cfg_err9,
  input  logic [2:0]  ttc_irq9,
  output logic        irq_event9,
  output logic [1:0]  irq_id9,
  output logic [5:0]  irq_status9,
  output logic        m_psel9,
  output logic        m_penable9,
  output logic        m_pwrite9,
  output logic [7:0]  m_paddr9,
  output logic [31:0] m_pwdata9,
  input  logic [31:0] m_prdata9
);

  localparam int unsigned NTMR_W  = 3;
  localparam int unsigned CLK_W   = 7;
  localparam int unsigned IV_W    = 48;
  localparam int unsigned IEN_W   = 6;
  localparam int unsigned STAT_W  = 6;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CFG_SETUP  = 3'd1;
  localparam logic [2:0] ST_CFG_ACCESS = 3'd2;
  localparam logic [2:0] ST_IRQ_SETUP  = 3'd3;
  localparam logic [2:0] ST_IRQ_ACCESS = 3'd4;
  localparam logic [2:0] ST_IRQ_SETTLE = 3'd5;

  logic [2:0]        state, state_d;
  logic [1:0]        tmr, tmr_d;
  logic [1:0]        step, step_d;
  logic [NTMR_W-1:0] cap_mask, cap_mask_d;
  logic [CLK_W-1:0]  cap_clk, cap_clk_d;
  logic [IV_W-1:0]   cap_iv, cap_iv_d;
  logic [IEN_W-1:0]  cap_ien, cap_ien_d;

  logic              busy_d, done_d, err_d, irq_event_d;
  logic [1:0]        irq_id_d;
  logic [STAT_W-1:0] irq_status_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic [2:0]        pick;

  // Only the low status bits are reported upstream.
  logic prdata_unused;
  assign prdata_unused = ^m_prdata9[DATA_W-1:STAT_W];

  // Lowest set bit of mask at or above index 'from'; result is {found, index}.
  function automatic logic [2:0] first_from(input logic [2:0] mask, input logic [1:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (2'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Register address for write 'st' of timer 't'.
  function automatic logic [7:0] beat_addr(input logic [1:0] t, input logic [1:0] st);
    logic [7:0] base;
    case (st)
      2'd0:    base = CLK_CTRL_BASE;
      2'd1:    base = INTERVAL_BASE;
      2'd2:    base = IRQ_EN_BASE;
      default: base = CNT_CTRL_BASE;
    endcase
    return 8'(base + 8'({t, 2'b00}));
  endfunction

  // Write data for write 'st' of timer 't' from the captured configuration.
  function automatic logic [31:0] beat_data(input logic [1:0] t, input logic [1:0] st,
                                            input logic [6:0] clk_v, input logic [47:0] iv,
                                            input logic [5:0] ien);
    logic [15:0] iv_t;
    case (t)
      2'd0:    iv_t = iv[15:0];
      2'd1:    iv_t = iv[31:16];
      default: iv_t = iv[47:32];
    endcase
    case (st)
      2'd0:    return {25'b0, clk_v};
      2'd1:    return {16'b0, iv_t};
      2'd2:    return {26'b0, ien};
      default: return CNT_CTRL_RUN;
    endcase
  endfunction

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d      = state;
    tmr_d        = tmr;
    step_d       = step;
    cap_mask_d   = cap_mask;
    cap_clk_d    = cap_clk;
    cap_iv_d     = cap_iv;
    cap_ien_d    = cap_ien;
    done_d       = 1'b0;
    err_d        = 1'b0;
    irq_event_d  = 1'b0;
    irq_id_d     = irq_id9;
    irq_status_d = irq_status9;
    psel_d       = 1'b0;
    penable_d    = 1'b0;
    pwrite_d     = 1'b0;
    paddr_d      = '0;
    pwdata_d     = '0;
    pick         = 3'b000;

    if (cfg_start9 && (state != ST_IDLE)) err_d = 1'b1;

    case (state)
      ST_IDLE: begin
        if (cfg_start9) begin
          cap_mask_d = cfg_tmr_en9;
          cap_clk_d  = cfg_clk_ctrl9;
          cap_iv_d   = cfg_interval9;
          cap_ien_d  = cfg_irq_en9;
          pick       = first_from(cfg_tmr_en9, 2'd0);
          if (pick[2]) begin
            tmr_d   = pick[1:0];
            step_d  = 2'd0;
            state_d = ST_CFG_SETUP;
          end else begin
            done_d = 1'b1;
          end
        end else if (|ttc_irq9) begin
          pick    = first_from(ttc_irq9, 2'd0);
          tmr_d   = pick[1:0];
          state_d = ST_IRQ_SETUP;
        end
      end
      ST_CFG_SETUP: state_d = ST_CFG_ACCESS;
      ST_CFG_ACCESS: begin
        if (step == 2'd3) begin
          pick = first_from(cap_mask, 2'(tmr + 2'd1));
          if (pick[2]) begin
            tmr_d   = pick[1:0];
            step_d  = 2'd0;
            state_d = ST_CFG_SETUP;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          step_d  = 2'(step + 2'd1);
          state_d = ST_CFG_SETUP;
        end
      end
      ST_IRQ_SETUP: state_d = ST_IRQ_ACCESS;
      ST_IRQ_ACCESS: begin
        irq_event_d  = 1'b1;
        irq_id_d     = 2'(tmr + 2'd1);
        irq_status_d = m_prdata9[STAT_W-1:0];
        state_d      = ST_IRQ_SETTLE;
      end
      ST_IRQ_SETTLE: state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase

    // Bus phase follows the state being entered so it lines up with the state register.
    case (state_d)
      ST_CFG_SETUP: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b1;
        paddr_d  = beat_addr(tmr_d, step_d);
        pwdata_d = beat_data(tmr_d, step_d, cap_clk_d, cap_iv_d, cap_ien_d);
      end
      ST_CFG_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        pwrite_d  = 1'b1;
        paddr_d   = m_paddr9;
        pwdata_d  = m_pwdata9;
      end
      ST_IRQ_SETUP: begin
        psel_d  = 1'b1;
        paddr_d = 8'(IRQ_STAT_BASE + 8'({tmr_d, 2'b00}));
      end
      ST_IRQ_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        paddr_d   = m_paddr9;
      end
      default: ;
    endcase

    busy_d = (state_d == ST_CFG_SETUP) || (state_d == ST_CFG_ACCESS);
  end

  // State, captured configuration and registered outputs.
  always_ff @(posedge pclk9 or negedge n_p_reset9) begin
    if (!n_p_reset9) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      step        <= '0;
      cap_mask    <= '0;
      cap_clk     <= '0;
      cap_iv      <= '0;
      cap_ien     <= '0;
      cfg_busy9   <= 1'b0;
      cfg_done9   <= 1'b0;
      cfg_err9    <= 1'b0;
      irq_event9  <= 1'b0;
      irq_id9     <= '0;
      irq_status9 <= '0;
      m_psel9     <= 1'b0;
      m_penable9  <= 1'b0;
      m_pwrite9   <= 1'b0;
      m_paddr9    <= '0;
      m_pwdata9   <= '0;
    end else begin
      state       <= state_d;
      tmr         <= tmr_d;
      step        <= step_d;
      cap_mask    <= cap_mask_d;
      cap_clk     <= cap_clk_d;
      cap_iv      <= cap_iv_d;
      cap_ien     <= cap_ien_d;
      cfg_busy9   <= busy_d;
      cfg_done9   <= done_d;
      cfg_err9    <= err_d;
      irq_event9  <= irq_event_d;
      irq_id9     <= irq_id_d;
      irq_status9 <= irq_status_d;
      m_psel9     <= psel_d;
      m_penable9  <= penable_d;
      m_pwrite9   <= pwrite_d;
      m_paddr9    <= paddr_d;
      m_pwdata9   <= pwdata_d;
    end
  end

endmodule
